// File: rtl/uart_pkg.sv
// Shared sizing constants for the UART datapath blocks.
package uart_pkg;
  localparam int UART_DATA_WIDTH      = 8;
  localparam int UART_FIFO_ADDR_WIDTH = 4;
endpackage

// File: rtl/uart_fifo_regfile.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset on contents.
module uart_fifo_regfile
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO with registered empty/full flags.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] r_data
);
  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH-1:0] w_ptr_inc, r_ptr_inc;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  wr_en, rd_en;

  // A write while full is allowed only when a pop frees the head slot on the same edge.
  assign rd_en     = rd & ~empty_q;
  assign wr_en     = wr & (~full_q | rd_en);
  assign w_ptr_inc = w_ptr_q + 1'b1;
  assign r_ptr_inc = r_ptr_q + 1'b1;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    empty_d = empty_q;
    full_d  = full_q;
    if (wr_en) w_ptr_d = w_ptr_inc;
    if (rd_en) r_ptr_d = r_ptr_inc;
    case ({wr_en, rd_en})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (w_ptr_inc == r_ptr_q);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (r_ptr_inc == w_ptr_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  uart_fifo_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(w_ptr_q),
    .wdata_i(w_data),
    .raddr_i(r_ptr_q),
    .rdata_o(r_data)
  );

  assign empty = empty_q;
  assign full  = full_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: vector table for short ops, hand sequences for fill/wrap/reset.
module tb_uart_fifo;
  logic       clk = 1'b0;
  logic       rst, rd, wr;
  logic [7:0] w_data;
  logic       empty, full;
  logic [7:0] r_data;

  int errors = 0;
  int checks = 0;

  uart_fifo dut (
    .clk   (clk),
    .rst   (rst),
    .rd    (rd),
    .wr    (wr),
    .w_data(w_data),
    .empty (empty),
    .full  (full),
    .r_data(r_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    logic       e_empty;
    logic       e_full;
    logic       chk_d;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, then idle the inputs.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; w_data = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; w_data = 8'h00;
  endtask

  task automatic check_flags(input string name, input logic e, input logic f);
    check({name, ".empty"}, {7'd0, empty}, {7'd0, e});
    check({name, ".full"},  {7'd0, full},  {7'd0, f});
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; w_data = 8'h00;

    //                 wr    rd    d      empty full  chk   data
    tbl[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55};
    tbl[5] = '{1'b1, 1'b0, 8'h66, 1'b0, 1'b0, 1'b1, 8'h55};
    tbl[6] = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'h66};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

    #20 rst = 1'b0;
    #2;
    check_flags("reset", 1'b1, 1'b0);

    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].d);
      check_flags($sformatf("vec%0d", i), tbl[i].e_empty, tbl[i].e_full);
      if (tbl[i].chk_d) check($sformatf("vec%0d.r_data", i), r_data, tbl[i].e_data);
    end

    // Fill to full, overflow write ignored, drain in order.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      if (i == 15) check_flags("fill15", 1'b0, 1'b0);
    end
    check_flags("fill16", 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'hAA);
    check_flags("overflow", 1'b0, 1'b1);
    check("overflow.head", r_data, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain%0d", i), r_data, 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    check_flags("drained", 1'b1, 1'b0);

    // Wrap-around: offset pointers by 10, then fill across the wrap.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("pre%0d", i), r_data, 8'hC0 + 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    check_flags("pre_empty", 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i));
    check_flags("wrap_full", 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap%0d", i), r_data, 8'h20 + 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    check_flags("wrap_empty", 1'b1, 1'b0);

    // Simultaneous push/pop while full: head leaves, new word goes last.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
    check_flags("sim_full", 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 8'h77);
    check_flags("sim_rw", 1'b0, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("sim%0d", i), r_data, 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end
    check("sim_last", r_data, 8'h77);
    check_flags("sim_last", 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00);
    check_flags("sim_empty", 1'b1, 1'b0);

    // Asynchronous reset between edges with 5 words held.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i));
    check_flags("pre_rst", 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_flags("async_rst", 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h99);
    check_flags("post_rst", 1'b0, 1'b0);
    check("post_rst.r_data", r_data, 8'h99);
    cyc(1'b0, 1'b1, 8'h00);
    check_flags("post_rst_pop", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
Synchronous single-clock FIFO buffering bytes between UART receiver/transmitter and host logic. Write port pushes `w_data` on `wr`; read port exposes the head word combinationally on `r_data` and pops on `rd`. `empty` and `full` flags are registered, for flow control by producer and consumer.

Parameters:
DATA_WIDTH, 8, bits per entry
ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (16 entries)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
rd  input  1  pop request; sampled on rising clk
wr  input  1  push request; sampled on rising clk
w_data  input  DATA_WIDTH  data to push
empty  output  1  FIFO holds 0 entries (registered)
full  output  1  FIFO holds 2**ADDR_WIDTH entries (registered)
r_data  output  DATA_WIDTH  head entry, first-word-fall-through (combinational read of mem[r_ptr])

Behaviour:
- Reset: asynchronous on rst=1. w_ptr=0, r_ptr=0, empty=1, full=0. Storage array is not reset. r_data is don't-care while empty=1.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array. Written synchronously at w_ptr when the write is accepted. Read asynchronously: r_data = mem[r_ptr].
- Write accepted when wr=1 and full=0. Write with full=1 is ignored: no pointer move, no data change.
- Read accepted when rd=1 and empty=0. r_ptr advances on that edge. Read with empty=1 is ignored.
- Pointers are ADDR_WIDTH bits and wrap naturally from 2**ADDR_WIDTH-1 to 0.
- Flag updates on the same edge as the operation. Status is visible the cycle after the edge.
  - Write only (accepted): empty<=0; full<=1 if the incremented w_ptr equals r_ptr.
  - Read only (accepted): full<=0; empty<=1 if the incremented r_ptr equals w_ptr.
  - wr=1 and rd=1, neither flag set: both pointers advance; flags unchanged.
  - wr=1 and rd=1 while empty: only the write occurs; empty<=0. A word written on an edge becomes the head after that edge, never on the same edge.
  - wr=1 and rd=1 while full: both occur (pop head, push new word into freed slot); full stays 1.
  - Neither: no change.
- empty and full are never both 1.
- Latency: a word written at edge N appears on r_data, with empty=0, after edge N.
- Reset asserted mid-operation: immediate return to reset state; all contents logically discarded.

Decomposition:
- Shared package uart_pkg: default DATA_WIDTH=8, FIFO ADDR_WIDTH=4 constants.
- One sub-module: uart_fifo_regfile, holding the storage array with synchronous write-enable port and asynchronous read port.
- uart_fifo keeps the pointer/flag control logic.

Test Plan:
- Reset: hold rst=1 for 20 ns, release -> empty=1, full=0; rd pulses with no writes leave empty=1 and pointers at 0.
- Single push/pop: write 0x01 -> after edge empty=0, r_data=0x01; pulse rd -> empty=1.
- Fill to full: write 0x01..0x10 (16 words) -> full=1 after 16th edge; a 17th write of 0xAA is ignored; pop all 16 -> r_data sequence 0x01..0x10, then empty=1.
- Wrap-around: push 10, pop 10, push 16 words 0x20..0x2F -> full=1; pops return 0x20..0x2F in order across the pointer wrap.
- Simultaneous rd/wr: at empty, wr=rd=1 with 0x55 -> only write, r_data=0x55, empty=0. At full, wr=rd=1 with 0x77 -> head popped, full stays 1, and 0x77 is read out last after the 15 remaining words.
- Async reset mid-stream: with 5 words held, assert rst between clock edges -> empty=1 and full=0 immediately, without waiting for a clock edge; the next write 0x99 reads back as 0x99.
